// File: rtl/mem_array_resp_pkg.sv
// Shared types for the memory-array responder: bus word, read-pipeline stage and bus opcode.
// BUSWIDTH is fixed here so every master and the array agree on the word size.
package mem_array_resp_pkg;

    localparam int BUSWIDTH = 8;

    typedef logic [BUSWIDTH-1:0] mem_word_t;

    typedef struct packed {
        logic      valid;
        mem_word_t data;
        logic      par;
    } rd_stage_t;

    // Decoded {rdEn, wrEn} pair sampled at each clock edge.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_ERROR = 2'b11
    } bus_op_e;

    function automatic logic evenPar(input mem_word_t d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_array_resp_if.sv
// Memory-array bus: request side (Addr/DataIn/rdEn/wrEn) driven by a master,
// response side (DataOut/rdValid/parErr) driven by the array.
interface mem_array_resp_if
    import mem_array_resp_pkg::*;
#(
    parameter int ADDRWIDTH = 12
);
    // No ready/backpressure: the array accepts whatever {rdEn,wrEn} holds at every
    // posedge, and rdValid is a one-cycle pulse marking a fresh DataOut word.
    logic [ADDRWIDTH-1:0] Addr;
    mem_word_t            DataIn;
    logic                 rdEn;
    logic                 wrEn;
    mem_word_t            DataOut;
    logic                 rdValid;
    logic                 parErr;

    modport master (
        output Addr, DataIn, rdEn, wrEn,
        input  DataOut, rdValid, parErr
    );

    modport slave (
        input  Addr, DataIn, rdEn, wrEn,
        output DataOut, rdValid, parErr
    );

endinterface

// File: rtl/mem_array_rdpipe.sv
// RD_LATENCY-deep shift register of read-pipeline stages; asynchronous clear drops
// every in-flight read so nothing is reported after a reset.
module mem_array_rdpipe
    import mem_array_resp_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic      clk,
    input  logic      resetN,
    input  rd_stage_t stageIn,
    output rd_stage_t stageOut
);

    rd_stage_t pipe [RD_LATENCY];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stageIn;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign stageOut = pipe[RD_LATENCY-1];

endmodule

// File: rtl/mem_array_resp.sv
// Array-side responder of the memory-array bus: storage, access decode, pipelined reads
// and a saturating protocol-error counter. Optional word parity under `MEM_PARITY_EN`.
module mem_array_resp
    import mem_array_resp_pkg::*;
#(
    parameter int ADDRWIDTH    = 12,
    parameter int RD_LATENCY   = 1,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    mem_array_resp_if.slave         bus,
    input  logic                    clrErr,
    output logic                    errSticky,
    output logic [ERRCNT_WIDTH-1:0] errCount
);

    localparam int DEPTH = 1 << ADDRWIDTH;

`ifdef MEM_PARITY_EN
    localparam int MEMW = BUSWIDTH + 1;
`else
    localparam int MEMW = BUSWIDTH;
`endif

    logic [MEMW-1:0] memArray [DEPTH];
    logic [MEMW-1:0] wrWord;
    logic [MEMW-1:0] rdWord;
    bus_op_e         op;
    rd_stage_t       stageIn;
    rd_stage_t       stageOut;

    assign op = bus_op_e'({bus.rdEn, bus.wrEn});

`ifdef MEM_PARITY_EN
    assign wrWord = {evenPar(bus.DataIn), bus.DataIn};
`else
    assign wrWord = bus.DataIn;
`endif

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (op == OP_WRITE) begin
            memArray[bus.Addr] <= wrWord;
        end
    end

    assign rdWord = memArray[bus.Addr];

    always_comb begin
        stageIn       = '0;
        stageIn.valid = (op == OP_READ);
        stageIn.data  = rdWord[BUSWIDTH-1:0];
`ifdef MEM_PARITY_EN
        stageIn.par   = rdWord[BUSWIDTH];
`endif
    end

    mem_array_rdpipe #(
        .RD_LATENCY (RD_LATENCY)
    ) uRdPipe (
        .clk      (clk),
        .resetN   (resetN),
        .stageIn  (stageIn),
        .stageOut (stageOut)
    );

    // Final register stage: DataOut only moves when a read completes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.DataOut <= '0;
            bus.rdValid <= 1'b0;
        end else begin
            bus.rdValid <= stageOut.valid;
            if (stageOut.valid) begin
                bus.DataOut <= stageOut.data;
            end
        end
    end

`ifdef MEM_PARITY_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.parErr <= 1'b0;
        end else begin
            bus.parErr <= stageOut.valid & (^{stageOut.data, stageOut.par});
        end
    end
`else
    logic unusedPar;
    assign unusedPar  = stageOut.par;
    assign bus.parErr = 1'b0;
`endif

    // An error on the same edge as clrErr restarts the count at one.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            errSticky <= 1'b0;
            errCount  <= '0;
        end else if (op == OP_ERROR) begin
            errSticky <= 1'b1;
            if (clrErr) begin
                errCount <= ERRCNT_WIDTH'(1);
            end else if (errCount != '1) begin
                errCount <= errCount + ERRCNT_WIDTH'(1);
            end
        end else if (clrErr) begin
            errSticky <= 1'b0;
            errCount  <= '0;
        end
    end

endmodule

// File: tb/tb_mem_array_resp.sv
// Scoreboard bench for mem_array_resp (RD_LATENCY=3): driver pushes expected read words,
// a negedge monitor pops them on rdValid and checks data, arrival cycle, hold and error state.
module tb_mem_array_resp;
  import mem_array_resp_pkg::*;

  localparam int AW  = 12;
  localparam int LAT = 3;
  localparam int EW  = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          clrErr = 1'b0;
  logic          errSticky;
  logic [EW-1:0] errCount;

  mem_array_resp_if #(.ADDRWIDTH(AW)) bus ();

  mem_array_resp #(
    .ADDRWIDTH    (AW),
    .RD_LATENCY   (LAT),
    .ERRCNT_WIDTH (EW)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .bus       (bus),
    .clrErr    (clrErr),
    .errSticky (errSticky),
    .errCount  (errCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference state
  mem_word_t refMem [int];
  bit        badPar [int];
  int        refErrCount = 0;
  bit        refSticky = 0;
  mem_word_t lastData = '0;

  logic [BUSWIDTH-1:0] exp_q [$];
  int                  due_q [$];
  bit                  par_q [$];

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // request-side sanity: controls must never be X/Z while out of reset
  always @(posedge clk) begin
    if (resetN) begin
      checks++;
      assert (!$isunknown({bus.rdEn, bus.wrEn})) else begin
        failures++;
        $display("FAIL ctrl_known: rdEn/wrEn=%b%b expected known levels", bus.rdEn, bus.wrEn);
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!resetN) begin
      check("reset_rdValid", bus.rdValid, 0);
      check("reset_DataOut", bus.DataOut, 0);
      lastData = '0;
    end else if (bus.rdValid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdValid", 1, 0);
      end else begin
        automatic mem_word_t d = exp_q.pop_front();
        automatic int        due = due_q.pop_front();
        automatic bit        p = par_q.pop_front();
        check("rd_data", bus.DataOut, d);
        check("rd_latency_cycle", cyc, due);
        check("rd_parErr", bus.parErr, p);
        lastData = d;
      end
    end else begin
      check("hold_DataOut", bus.DataOut, lastData);
    end
    check("errSticky", errSticky, refSticky);
    check("errCount", errCount, refErrCount);
  end

  task automatic busOp(input bit rd, input bit wr, input int a, input int d, input bit clr);
    @(negedge clk);
    bus.rdEn   = rd;
    bus.wrEn   = wr;
    bus.Addr   = AW'(a);
    bus.DataIn = BUSWIDTH'(d);
    clrErr     = clr;
    @(posedge clk);
    if (rd && !wr) begin
      exp_q.push_back(refMem[a]);
      due_q.push_back(cyc + LAT + 1);
      par_q.push_back(badPar.exists(a));
    end else if (wr && !rd) begin
      refMem[a] = BUSWIDTH'(d);
      if (badPar.exists(a)) badPar.delete(a);
    end
    if (rd && wr) begin
      refSticky = 1;
      refErrCount = clr ? 1 : ((refErrCount < ERR_MAX) ? refErrCount + 1 : ERR_MAX);
    end else if (clr) begin
      refSticky = 0;
      refErrCount = 0;
    end
    #1;
    bus.rdEn = 1'b0;
    bus.wrEn = 1'b0;
    clrErr   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulseReset();
    #1;
    resetN = 1'b0;
    exp_q.delete();
    due_q.delete();
    par_q.delete();
    refSticky = 0;
    refErrCount = 0;
    repeat (2) @(negedge clk);
    #2;
    resetN = 1'b1;
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("drain_pending_reads", exp_q.size(), 0);
  endtask

  initial begin
    bus.rdEn = 1'b0;
    bus.wrEn = 1'b0;
    bus.Addr = '0;
    bus.DataIn = '0;
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;

    // basic write then read
    busOp(0, 1, 'h005, 'h3C, 0);
    busOp(1, 0, 'h005, 0, 0);
    drain();

    // back-to-back reads return in consecutive cycles, in order
    busOp(0, 1, 'h001, 'hA1, 0);
    busOp(0, 1, 'h002, 'hB2, 0);
    busOp(0, 1, 'h003, 'hC3, 0);
    busOp(1, 0, 'h001, 0, 0);
    busOp(1, 0, 'h002, 0, 0);
    busOp(1, 0, 'h003, 0, 0);
    drain();

    // read-then-write and write-then-read hazards
    busOp(0, 1, 'h010, 'h11, 0);
    busOp(1, 0, 'h010, 0, 0);
    busOp(0, 1, 'h010, 'h22, 0);
    busOp(1, 0, 'h010, 0, 0);
    drain();

    // protocol error leaves memory alone; counter saturates; clear vs error priority
    busOp(0, 1, 'h020, 'h5A, 0);
    busOp(1, 1, 'h020, 'hFF, 0);
    busOp(1, 0, 'h020, 0, 0);
    drain();
    for (int i = 0; i < 300; i++) busOp(1, 1, $urandom_range(0, 4095), $urandom_range(0, 255), 0);
    idleCycles(1);
    busOp(1, 1, 'h020, 'h00, 1);
    busOp(0, 0, 'h000, 'h00, 1);
    idleCycles(2);

    // reset in the middle of a 3-deep burst discards it; array keeps its data
    busOp(1, 0, 'h005, 0, 0);
    busOp(1, 0, 'h001, 0, 0);
    busOp(1, 0, 'h002, 0, 0);
    pulseReset();
    idleCycles(LAT + 3);
    busOp(1, 0, 'h005, 0, 0);
    drain();

`ifdef MEM_PARITY_EN
    busOp(0, 1, 'h007, 'h81, 0);
    @(negedge clk);
    dut.memArray[7][BUSWIDTH] = ~dut.memArray[7][BUSWIDTH];
    badPar[7] = 1;
    busOp(1, 0, 'h007, 0, 0);
    busOp(1, 0, 'h005, 0, 0);
    drain();
`endif

    // randomized traffic over a preloaded window
    for (int a = 'h40; a < 'h80; a++) busOp(0, 1, a, $urandom_range(0, 255), 0);
    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 9);
      automatic int a = 'h40 + $urandom_range(0, 63);
      case (r)
        0, 1, 2, 3: busOp(1, 0, a, 0, 0);
        4, 5, 6:    busOp(0, 1, a, $urandom_range(0, 255), 0);
        7:          busOp(1, 1, a, $urandom_range(0, 255), $urandom_range(0, 1));
        8:          idleCycles($urandom_range(1, 3));
        default:    busOp(0, 0, a, 0, 1);
      endcase
    end
    drain();
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
